// File: rtl/inta_sequencer.sv
// CPU-side 8259A acknowledge initiator: watches INT, issues the two INTA_bar
// pulses, captures the vector on the closing edge of pulse 2 and offers it over valid/ready.
module inta_sequencer #(
  parameter int PULSE_LOW_CYCLES = 2,
  parameter int GAP_CYCLES       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       int_req,
  input  logic       int_enable,
  input  logic [7:0] data_in,
  output logic       inta_n,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  input  logic       vec_ready,
  output logic       busy,
  output logic [7:0] ack_cnt
);

  localparam int MAX_CYCLES = (PULSE_LOW_CYCLES > GAP_CYCLES) ? PULSE_LOW_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LOW_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P1_LOW = 3'd1,
    GAP    = 3'd2,
    P2_LOW = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t           state_reg;
  logic             sync1_reg;
  logic             int_sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             last_cycle;

  // The counter is loaded with the full phase length, so a value of one marks the final cycle.
  assign last_cycle = (cnt_reg == CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sync1_reg    <= 1'b0;
      int_sync_reg <= 1'b0;
      cnt_reg      <= '0;
      inta_n       <= 1'b1;
      vec_valid    <= 1'b0;
      vec_data     <= 8'h00;
      busy         <= 1'b0;
      ack_cnt      <= 8'h00;
    end else begin
      sync1_reg    <= int_req;
      int_sync_reg <= sync1_reg;
      case (state_reg)
        IDLE: begin
          if (int_sync_reg && int_enable) begin
            state_reg <= P1_LOW;
            inta_n    <= 1'b0;
            cnt_reg   <= PULSE_LOAD;
            busy      <= 1'b1;
          end
        end
        // Once pulse 1 is out the PIC has latched ISR, so nothing aborts the sequence.
        P1_LOW: begin
          if (last_cycle) begin
            state_reg <= GAP;
            inta_n    <= 1'b1;
            cnt_reg   <= GAP_LOAD;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        GAP: begin
          if (last_cycle) begin
            state_reg <= P2_LOW;
            inta_n    <= 1'b0;
            cnt_reg   <= PULSE_LOAD;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        P2_LOW: begin
          if (last_cycle) begin
            state_reg <= HOLD;
            inta_n    <= 1'b1;
            cnt_reg   <= '0;
            vec_data  <= data_in;
            vec_valid <= 1'b1;
            ack_cnt   <= ack_cnt + 8'd1;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        HOLD: begin
          if (vec_valid && vec_ready) begin
            state_reg <= IDLE;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            cnt_reg   <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          inta_n    <= 1'b1;
          vec_valid <= 1'b0;
          busy      <= 1'b0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: a PIC-side responder supplies vectors into a scoreboard,
// and a monitor compares every output each cycle against a schedule-based reference model.
`timescale 1ns/1ps
module tb_inta_sequencer;

  localparam int P   = 2;
  localparam int G   = 2;
  localparam int CAP = 2*P + G;   // edge offset (from the first fall) at which the vector is captured

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       int_req = 1'b0, int_enable = 1'b0, vec_ready = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       inta_n, vec_valid, busy;
  logic [7:0] vec_data, ack_cnt;

  logic       int_req_b = 1'b0, int_enable_b = 1'b1, vec_ready_b = 1'b1;
  logic [7:0] data_in_b = 8'h5A;
  logic       inta_n_b, vec_valid_b, busy_b;
  logic [7:0] vec_data_b, ack_cnt_b;

  int         total = 0;
  int         bad = 0;
  logic [7:0] sb[$];
  int         vec_override = -1;
  int         m_total = 0;

  inta_sequencer #(.PULSE_LOW_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .int_enable(int_enable),
    .data_in(data_in), .inta_n(inta_n), .vec_valid(vec_valid), .vec_data(vec_data),
    .vec_ready(vec_ready), .busy(busy), .ack_cnt(ack_cnt)
  );

  inta_sequencer #(.PULSE_LOW_CYCLES(1), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .int_req(int_req_b), .int_enable(int_enable_b),
    .data_in(data_in_b), .inta_n(inta_n_b), .vec_valid(vec_valid_b), .vec_data(vec_data_b),
    .vec_ready(vec_ready_b), .busy(busy_b), .ack_cnt(ack_cnt_b)
  );

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // PIC-side responder: drives a fresh vector for the whole of every second pulse, junk otherwise.
  int         pulse_no = 0;
  logic       inta_prev = 1'b1;
  logic [7:0] resp_vec;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pulse_no  = 0;
      inta_prev = 1'b1;
      data_in   = 8'($urandom);
    end else begin
      if (!inta_n && inta_prev) begin
        pulse_no++;
        if (pulse_no % 2 == 0) begin
          resp_vec = (vec_override >= 0) ? 8'(vec_override) : 8'($urandom);
          sb.push_back(resp_vec);
          data_in = resp_vec;
        end else begin
          data_in = 8'($urandom);
        end
      end else if (inta_n || (pulse_no % 2 == 1)) begin
        data_in = 8'($urandom);
      end
      inta_prev = inta_n;
    end
  end

  // Reference model: a sequence starting at edge s has INTA low on edges [s,s+P) and
  // [s+P+G,s+CAP), the vector valid from edge s+CAP until the edge that sees ready.
  int         n = 0, m_start = 0, m_ack = 0, d;
  bit         m_active = 0, first = 1;
  logic [7:0] m_vec = 8'h00;
  bit         req_q0, req_q1, req_q2, en_q, rdy_q;
  bit         exp_inta, exp_valid, exp_busy;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_ack = 0; m_vec = 8'h00; n = 0; first = 1;
      req_q0 = 0; req_q1 = 0; req_q2 = 0;
      sb.delete();
      chk("rst_inta_n", int'(inta_n), 1);
      chk("rst_vec_valid", int'(vec_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ack_cnt", int'(ack_cnt), 0);
      chk("rst_vec_data", int'(vec_data), 0);
    end else begin
      if (!first) begin
        n++;
        if (!m_active) begin
          if (req_q2 && en_q) begin
            m_active = 1;
            m_start  = n;
          end
        end else if ((n - m_start > CAP) && rdy_q) begin
          m_active = 0;
        end
        if (m_active && (n - m_start == CAP)) begin
          chk("sb_has_vec", int'(sb.size() > 0), 1);
          if (sb.size() > 0) m_vec = sb.pop_front();
          m_ack = (m_ack + 1) % 256;
          m_total++;
        end
      end
      first = 0;
      d = n - m_start;
      exp_inta  = m_active ? !((d < P) || (d >= P + G && d < CAP)) : 1'b1;
      exp_valid = m_active && (d >= CAP);
      exp_busy  = m_active;
      chk("inta_n", int'(inta_n), int'(exp_inta));
      chk("vec_valid", int'(vec_valid), int'(exp_valid));
      chk("busy", int'(busy), int'(exp_busy));
      chk("ack_cnt", int'(ack_cnt), m_ack);
      chk("vec_data", int'(vec_data), int'(m_vec));
      req_q2 = req_q1; req_q1 = req_q0; req_q0 = int_req;
      en_q = int_enable; rdy_q = vec_ready;
    end
  end

  task automatic step(int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // which: 0 = in the gap between pulses, 1 = INTA low, 2 = vector valid
  task automatic wait_for(int which, string name);
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if ((which == 0 && busy && inta_n && !vec_valid) ||
          (which == 1 && !inta_n) ||
          (which == 2 && vec_valid)) begin
        ok = 1;
        break;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  base;
    bit  smp[40];
    int  idx, l1, g1, l2;

    // Plain acknowledge with ready always high
    int_req = 1; int_enable = 1; vec_ready = 1;
    step(2);
    rst_n = 1;
    step(30);

    // Interrupts disabled: no pulses, then enabling starts one immediately
    int_enable = 0;
    step(20);
    int_enable = 1;
    step(15);

    // Drop the request mid-sequence, then stall the consumer
    wait_for(0, "wait_gap_t3");
    vec_override = 8'h21;
    int_req = 0; int_enable = 0; vec_ready = 0;
    wait_for(2, "wait_valid_t3");
    chk("t3_vec_data", int'(vec_data), 8'h21);
    vec_override = -1;
    int_req = 1; int_enable = 1;
    step(10);
    chk("t4_hold_valid", int'(vec_valid), 1);
    chk("t4_hold_data", int'(vec_data), 8'h21);
    chk("t4_hold_inta_n", int'(inta_n), 1);
    vec_ready = 1;
    step(4);

    // Asynchronous reset in the middle of pulse 2
    wait_for(0, "wait_gap_t5");
    wait_for(1, "wait_p2_t5");
    #2;
    rst_n = 0;
    #1;
    chk("t5_inta_n_async", int'(inta_n), 1);
    chk("t5_vec_valid_async", int'(vec_valid), 0);
    chk("t5_ack_cnt_async", int'(ack_cnt), 0);
    chk("t5_busy_async", int'(busy), 0);
    step(2);
    rst_n = 1;

    // Random traffic past the ack counter wrap
    base = m_total;
    for (int i = 0; i < 20000; i++) begin
      int_req    = ($urandom_range(0, 3) != 0);
      int_enable = ($urandom_range(0, 3) != 0);
      vec_ready  = ($urandom_range(0, 2) != 0);
      step();
      if (m_total - base >= 260) break;
    end
    chk("t6_enough_acks", int'(m_total - base >= 260), 1);
    int_req = 0; vec_ready = 1;
    step(20);
    chk("sb_drained", sb.size(), 0);

    // Second instance with 1/3 timing: measure the pulse widths directly
    int_req_b = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      smp[i] = inta_n_b;
      if (!inta_n_b) int_req_b = 0;
    end
    idx = 0;
    while (idx < 40 && smp[idx]) idx++;
    l1 = 0; while (idx < 40 && !smp[idx]) begin l1++; idx++; end
    g1 = 0; while (idx < 40 && smp[idx])  begin g1++; idx++; end
    l2 = 0; while (idx < 40 && !smp[idx]) begin l2++; idx++; end
    chk("b_pulse1_width", l1, 1);
    chk("b_gap_width", g1, 3);
    chk("b_pulse2_width", l2, 1);
    chk("b_vec_data", int'(vec_data_b), 8'h5A);
    chk("b_ack_cnt", int'(ack_cnt_b), 1);
    chk("b_busy", int'(busy_b), 0);
    chk("b_vec_valid", int'(vec_valid_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
